// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the instruction-memory loader
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Width of the word-count header and of the word index
    localparam int HDR_W          = 16;
    // Bytes packed into each instruction word
    localparam int BYTES_PER_WORD = 4;

    localparam int c_WORD_W = 8 * BYTES_PER_WORD;
    localparam int c_BCNT_W = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Big-endian byte-to-word shift register with byte counter.
//                The first byte of a word ends up in the most significant lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import loader_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                shift_en,
    input  logic [7:0]          byte_in,
    output logic [c_WORD_W-1:0] word_out,
    output logic                last_byte
);

    logic [c_WORD_W-1:0] r_word;
    logic [c_BCNT_W-1:0] r_byte_cnt;

    // Shift bytes in from the bottom; clr restarts the byte count only, so the
    // completed word stays visible while it is being written out.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (shift_en) begin
                r_word <= {r_word[c_WORD_W-9:0], byte_in};
            end
            if (clr) begin
                r_byte_cnt <= '0;
            end else if (shift_en) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    assign word_out  = r_word;
    assign last_byte = (r_byte_cnt == c_BCNT_W'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction memory writer. Parses a 16-bit word
//                count header from a byte stream, assembles big-endian words,
//                writes them at consecutive word-aligned addresses from 0 and
//                holds the core in reset until the image is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [c_WORD_W-1:0] mem_wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error
);

    state_t             r_state;
    logic [HDR_W-1:0]   r_n;
    logic [HDR_W-1:0]   r_word_idx;
    logic [7:0]         r_len_hi;

    logic               w_rx_fire;
    logic               w_start_ok;
    logic [HDR_W-1:0]   w_hdr;
    logic               w_shift;
    logic               w_clr;
    logic               w_last_byte;
    logic               w_last_word;
    logic [c_WORD_W-1:0] w_word;

    assign w_rx_fire   = rx_valid & rx_ready;
    // start only has an effect when no load is running
    assign w_start_ok  = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERR));
    assign w_hdr       = {r_len_hi, rx_data};
    assign w_shift     = w_rx_fire & (r_state == ST_DATA);
    assign w_clr       = w_start_ok | (r_state == ST_WRITE);
    assign w_last_word = ((r_word_idx + HDR_W'(1)) == r_n);

    word_assembler u_word_assembler (
        .clock     (clock),
        .reset     (reset),
        .clr       (w_clr),
        .shift_en  (w_shift),
        .byte_in   (rx_data),
        .word_out  (w_word),
        .last_byte (w_last_byte)
    );

    // Load sequencer: header parse, word collection and one write per word
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_word_idx <= '0;
            r_len_hi   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_start_ok) begin
                        r_state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_rx_fire) begin
                        r_len_hi <= rx_data;
                        r_state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_rx_fire) begin
                        r_n        <= w_hdr;
                        r_word_idx <= '0;
                        if (w_hdr == '0) begin
                            r_state <= ST_DONE;
                        end else if (32'(w_hdr) > DEPTH) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_shift && w_last_byte) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_last_word) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_word_idx <= r_word_idx + HDR_W'(1);
                        r_state    <= ST_DATA;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state, so rx_ready never depends on rx_valid
    assign rx_ready  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                       (r_state == ST_DATA);
    assign busy      = rx_ready || (r_state == ST_WRITE);
    assign mem_we    = (r_state == ST_WRITE);
    assign mem_addr  = AW'(r_word_idx) << 2;
    assign mem_wdata = w_word;
    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_ERR);
    assign cpu_hold  = (r_state != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader: table of load scenarios,
//                randomized loads against a list-of-words model, and
//                hand-written sequences for reset and start corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int c_DEPTH = 256;
    localparam int c_AW    = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_ready;
    logic            mem_we;
    logic [c_AW-1:0] mem_addr;
    logic [31:0]     mem_wdata;
    logic            cpu_hold;
    logic            busy;
    logic            done;
    logic            error;

    imem_loader #(.DEPTH(c_DEPTH), .AW(c_AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_ready_bad = 0;
    bit          aborted = 1'b0;
    logic [63:0] wq [$];
    logic [7:0]  img [1024];

    typedef struct {
        int   n;
        int   gap;
        int   exp_cyc;
        logic exp_done;
        logic exp_err;
    } vec_t;
    vec_t tbl [5];

    // Edge counter used for latency checks
    always @(posedge clock) cyc <= cyc + 1;

    // Capture every memory write away from the clock edge
    always @(negedge clock) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            if (rx_ready) wr_ready_bad++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one byte after an optional bubble; hold it until it is accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  g;
        bit  acc;
        if (aborted) return;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        rx_valid = 1'b0;
        repeat (g) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            acc = rx_ready;
            @(posedge clock);
            #1;
            if (acc) break;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            aborted = 1'b1;
            chk("byte_accept", 64'(acc), 64'd1);
        end
    endtask

    task automatic fill_img();
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
    endtask

    function automatic logic [63:0] exp_write(input int i);
        return {32'(4 * i), img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
    endfunction

    // One full load: start pulse, header, as many data bytes as the image needs
    task automatic do_load(input int n, input int gap, input int exp_cyc,
                           input logic exp_done, input logic exp_err, input string tag);
        int          c0;
        int          nw;
        logic [15:0] h;
        h  = 16'(n);
        nw = (n > 0 && n <= c_DEPTH) ? n : 0;
        wq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        send_byte(h[15:8], gap);
        send_byte(h[7:0], gap);
        for (int i = 0; i < 4 * nw; i++) send_byte(img[i], gap);
        for (int k = 0; k < 40 && !(done || error); k++) tick();
        chk({tag, "_status"}, 64'({done, error, cpu_hold, busy}),
            64'({exp_done, exp_err, ~exp_done, 1'b0}));
        if (exp_cyc > 0) chk({tag, "_cycles"}, 64'(cyc - c0 + 1), 64'(exp_cyc));
        chk({tag, "_wcount"}, 64'(wq.size()), 64'(nw));
        for (int i = 0; i < nw && i < wq.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), wq[i], exp_write(i));
    endtask

    initial begin : main
        int          n;
        int          kind;
        logic [63:0] w0;
        logic [63:0] w1;

        tbl[0] = '{2,   0, 13,   1'b1, 1'b0};
        tbl[1] = '{0,   0, 3,    1'b1, 1'b0};
        tbl[2] = '{257, 0, 3,    1'b0, 1'b1};
        tbl[3] = '{3,   1, 0,    1'b1, 1'b0};
        tbl[4] = '{256, 0, 1283, 1'b1, 1'b0};

        repeat (3) tick();
        chk("reset_outputs",
            {rx_ready, mem_we, cpu_hold, busy, done, error, 26'd0, mem_addr[31:0]},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0});
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        tick();

        // Table-driven scenarios
        for (int v = 0; v < 5; v++) begin
            fill_img();
            if (v == 0) begin
                img[0] = 8'h24; img[1] = 8'h08; img[2] = 8'h00; img[3] = 8'h05;
                img[4] = 8'h8C; img[5] = 8'h09; img[6] = 8'h00; img[7] = 8'h00;
            end
            do_load(tbl[v].n, tbl[v].gap, tbl[v].exp_cyc, tbl[v].exp_done,
                    tbl[v].exp_err, $sformatf("tbl%0d", v));
            if (v == 0) begin
                w0 = (wq.size() > 0) ? wq[0] : 64'd0;
                w1 = (wq.size() > 1) ? wq[1] : 64'd0;
                chk("plan_word0", w0, {32'd0, 32'h24080005});
                chk("plan_word1", w1, {32'd4, 32'h8C090000});
            end
        end

        // Randomized loads, including retries out of ERR
        for (int r = 0; r < 8; r++) begin
            fill_img();
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      n = 0;
            else if (kind == 1) n = c_DEPTH + 1 + int'($urandom_range(0, 1000));
            else                n = int'($urandom_range(1, 6));
            do_load(n, -1, 0, (n <= c_DEPTH), (n > c_DEPTH), $sformatf("rnd%0d", r));
        end

        // Reset in the middle of word 1 of 3, then a clean reload
        fill_img();
        wq.delete();
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_state", 64'({cpu_hold, busy, rx_ready, done, error, mem_we}),
            64'(6'b100000));
        chk("rst_mid_writes", 64'(wq.size()), 64'd1);
        fill_img();
        do_load(3, 0, 18, 1'b1, 1'b0, "reload");

        // start while in DATA is ignored; start in DONE begins a reload
        fill_img();
        wq.delete();
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(img[0], 0);
        send_byte(img[1], 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_in_data", 64'({busy, rx_ready, done, cpu_hold}), 64'(4'b1101));
        for (int i = 2; i < 8; i++) send_byte(img[i], 0);
        for (int k = 0; k < 20 && !done; k++) tick();
        chk("sid_wcount", 64'(wq.size()), 64'd2);
        for (int i = 0; i < 2 && i < wq.size(); i++)
            chk($sformatf("sid_w%0d", i), wq[i], exp_write(i));
        chk("sid_done", 64'({done, cpu_hold}), 64'(2'b10));
        start = 1'b1; tick(); start = 1'b0;
        chk("start_in_done", 64'({cpu_hold, busy, rx_ready, done}), 64'(4'b1110));
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("empty_after_restart", 64'({done, cpu_hold}), 64'(2'b10));

        chk("ready_in_write", 64'(wr_ready_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. It accepts a byte stream over a valid/ready handshake, parses a 16-bit word-count header, assembles big-endian 32-bit instruction words and issues one write per word at word-aligned byte addresses starting at 0. It holds the core in reset with `cpu_hold` until the image is fully written, then releases it. It sits between the host/UART byte source and the write port of the instruction memory, and drives the reset of the `mips` top.

## Interface
- `DEPTH`, 256: instruction memory capacity in 32-bit words.
- `AW`, 32: width of `mem_addr` (byte address, matches PC width).
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle; a byte transfers when `rx_valid & rx_ready`.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  AW  byte address of the write, equal to `word_idx*4`.
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  high keeps the core in reset.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed successfully.
- `error`  out  1  the header was rejected (N > DEPTH).

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE: on `start`, move to LEN_HI and clear `done` and `error`.
- LEN_HI / LEN_LO: each state consumes one byte, most significant byte first, forming the 16-bit count N.
- After LEN_LO:
  - N=0: go to DONE with no writes.
  - N>DEPTH: go to ERR.
  - Otherwise: go to DATA with `word_idx`=0 and `byte_cnt`=0.
- DATA: each accepted byte shifts into the word, big-endian. The first byte lands in [31:24].
  - `byte_cnt` is 2 bits wide.
  - When the 4th byte is accepted (`byte_cnt`==3), go to WRITE.
- WRITE: drive `mem_we`=1, `mem_addr`=`word_idx`<<2 and `mem_wdata`=the assembled word for exactly one cycle.
  - If `word_idx`+1==N, go to DONE.
  - Else increment `word_idx`, clear `byte_cnt` and return to DATA.
- DONE: `done`=1 and `cpu_hold`=0. `start` begins a new load (LEN_HI, `cpu_hold`=1).
- ERR: `error`=1 and `cpu_hold` stays 1. `start` retries the load from LEN_HI.
- `rx_ready`=1 only in LEN_HI, LEN_LO and DATA.
- `busy`=1 in LEN_HI, LEN_LO, DATA and WRITE.
- `start` during a busy state is ignored.
- `rx_valid` without `rx_ready` has no effect. The loader never drops a byte and never consumes a byte twice.
- All counters have fixed widths:
  - N: 16 bits.
  - `word_idx`: 16 bits, with the compare done at full width.
  - Address: `word_idx` zero-extended to AW, then shifted left by 2.

## Timing
- Reset values: state=IDLE, `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `error`=0.
- `reset` overrides everything in the same edge, including during a load. Words already written are not invalidated. `cpu_hold` returns to 1.
- All outputs are registered or decoded from the registered state. There is no combinational path from `rx_valid` to `rx_ready`.
- Write latency: `mem_we` asserts in the cycle after the edge that accepted the 4th byte of a word.
- With `rx_valid` held high, one word takes 5 cycles (4 accept cycles plus 1 WRITE cycle).
- Image load latency with continuous `rx_valid`: 1 cycle (start) + 2 header cycles + 5N cycles. DONE is entered on the edge that ends the last WRITE.
- `cpu_hold` falls on entry to DONE. The memory write completes on that same edge, so the core's first fetch sees word 0.

## Structure
- Package `loader_pkg` holds:
  - the state enum/localparams;
  - `HDR_W`=16;
  - `BYTES_PER_WORD`=4.
- Sub-module `word_assembler` holds the shift register and `byte_cnt`. Its ports are `clock`, `reset`, `clr`, `shift_en`, `byte_in`, `word_out` and `last_byte`.
- The FSM, `word_idx` and N stay in `imem_loader`.

## Test plan
- Header 00 02, then 24 08 00 05 and 8C 09 00 00 with `rx_valid` held high:
  - writes 0x24080005@0 and 0x8C090000@4;
  - `done`=1 and `cpu_hold`=0 at cycle 13.
- Header 00 00: no `mem_we`; DONE two cycles after `start`.
- Header 01 01 with `DEPTH`=256: ERR with `error`=1 and `cpu_hold`=1; no writes.
- Gapped `rx_valid` (a one-cycle bubble between every byte) with N=3:
  - three writes at addresses 0, 4 and 8 with correct data;
  - `rx_ready` is low in every WRITE cycle.
- `reset` asserted mid-word during word 1 of 3: next cycle IDLE, `cpu_hold`=1 and `busy`=0. A following `start` reloads correctly from address 0.
- `start` pulsed while in DATA: ignored, with no change to `word_idx`. `start` in DONE begins a reload and raises `cpu_hold`.
